// File: rtl/bcd_display_sequencer.sv
// Sequential double-dabble binary-to-BCD converter with a multiplexed 7-segment scanner.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module bcd_display_sequencer #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DIGITS   = 5,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [6:0]            seg_o,
    output logic [DIGITS-1:0]     an_o
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e             r_state, w_state_next;
    logic [DATA_W-1:0]  r_shreg, w_shreg_next;
    logic [BW-1:0]      r_acc, w_acc_next, w_acc_adj;
    logic [CW-1:0]      r_cnt, w_cnt_next;
    logic [BW-1:0]      r_bcd, w_bcd_next;
    logic               r_done, w_done_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_shreg <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_shreg <= w_shreg_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_bcd   <= w_bcd_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_acc_adj = r_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_acc[4*d +: 4] >= 4'd5) begin
                w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shreg_next = r_shreg;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_bcd_next   = r_bcd;
        w_done_next  = 1'b0;
        case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_shreg_next = data_i;
                    w_acc_next   = '0;
                    w_cnt_next   = CW'(DATA_W);
                    w_state_next = StConv;
                end
            end
            StConv: begin
                {w_acc_next, w_shreg_next} = {w_acc_adj, r_shreg} << 1;
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_bcd_next   = r_acc;
                w_done_next  = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign busy_o = (r_state == StConv);
    assign done_o = r_done;
    assign bcd_o  = r_bcd;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h7F;
        endcase
    endfunction

    logic [PW-1:0]     r_presc, w_presc_next;
    logic [IW-1:0]     r_idx, w_idx_next;
    logic              r_lit, w_lit_next, w_wrap, w_blank;
    logic [3:0]        w_digit;
    logic [DIGITS-1:0] r_an, w_an_next;
    logic [6:0]        r_seg, w_seg_next;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_lit   <= 1'b0;
            r_an    <= '1;
            r_seg   <= 7'h7F;
        end else begin
            r_presc <= w_presc_next;
            r_idx   <= w_idx_next;
            r_lit   <= w_lit_next;
            r_an    <= w_an_next;
            r_seg   <= w_seg_next;
        end
    end

    // The first wrap only lights digit 0; later wraps advance the index.
    always_comb begin
        w_wrap       = (r_presc == PW'(SCAN_DIV - 1));
        w_presc_next = w_wrap ? '0 : r_presc + PW'(1);
        w_lit_next   = r_lit | w_wrap;
        w_idx_next   = r_idx;
        if (w_wrap && r_lit) begin
            w_idx_next = (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end
        w_digit = 4'd0;
        w_blank = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (w_idx_next == IW'(d)) begin
                w_digit = r_bcd[4*d +: 4];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (w_idx_next != '0);
        for (int d = 0; d < DIGITS; d++) begin
            if ((IW'(d) >= w_idx_next) && (r_bcd[4*d +: 4] != 4'd0)) begin
                w_blank = 1'b0;
            end
        end
`endif
        w_an_next  = w_lit_next ? ~(DIGITS'(1) << w_idx_next) : '1;
        w_seg_next = (w_lit_next && !w_blank) ? seg_decode(w_digit) : 7'h7F;
    end

    assign an_o  = r_an;
    assign seg_o = r_seg;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Self-checking bench for bcd_display_sequencer: randomized conversions against an arithmetic
// decimal model, latency/busy accounting, ignored starts, reset abort and display scanning.
module tb_bcd_display_sequencer;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned DIGITS   = 5;
    localparam int unsigned SCAN_DIV = 4;
    localparam int          LAT      = DATA_W + 1;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                start_i = 1'b0;
    logic [DATA_W-1:0]   data_i = '0;
    logic                busy_o, done_o;
    logic [4*DIGITS-1:0] bcd_o;
    logic [6:0]          seg_o;
    logic [DIGITS-1:0]   an_o;

    int n_cmp = 0;
    int n_err = 0;

    bcd_display_sequencer #(
        .DATA_W   (DATA_W),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start_i),
        .data_i  (data_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .bcd_o   (bcd_o),
        .seg_o   (seg_o),
        .an_o    (an_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4*DIGITS-1:0] model_bcd(input logic [DATA_W-1:0] v);
        int unsigned x = v;
        logic [4*DIGITS-1:0] r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] model_seg(input logic [4*DIGITS-1:0] b, input int idx);
        logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        int unsigned val = 0;
        for (int d = DIGITS - 1; d >= 0; d--) val = val * 10 + int'(b[4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && val < 10 ** idx) return 7'h7F;
`endif
        return tab[(val / (10 ** idx)) % 10];
    endfunction

    // Starts a conversion and watches a fixed window; optionally pokes start during CONV/DONE.
    task automatic run_conv(input logic [DATA_W-1:0] v, input int win, input bit poke,
                            output int done_at, output int done_cnt, output int busy_cnt);
        data_i  = v;
        start_i = 1'b1;
        tick();
        start_i  = 1'b0;
        done_at  = -1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < win; c++) begin
            if (busy_o) busy_cnt++;
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (poke && (c == 4 || c == 9 || c == LAT - 1)) begin
                start_i = 1'b1;
                data_i  = 16'd9;
            end else begin
                start_i = 1'b0;
            end
            tick();
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_cmp += 5;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %h want 0", busy_o); end
        if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %h want 0", done_o); end
        if (bcd_o !== '0) begin n_err++; $display("FAIL reset_bcd got %h want 0", bcd_o); end
        if (an_o !== 5'h1F) begin n_err++; $display("FAIL reset_an got %h want 1f", an_o); end
        if (seg_o !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h want 7f", seg_o); end
        reset = 1'b1;
        repeat (SCAN_DIV - 1) tick();
        n_cmp++;
        if (an_o !== 5'h1F) begin n_err++; $display("FAIL prewrap_an got %h want 1f", an_o); end
        tick();
        n_cmp += 2;
        if (an_o !== 5'h1E) begin n_err++; $display("FAIL firstlit_an got %h want 1e", an_o); end
        if (seg_o !== 7'h40) begin n_err++; $display("FAIL firstlit_seg got %h want 40", seg_o); end
    endtask

    task automatic test_value(input logic [DATA_W-1:0] v, input string name);
        int done_at, done_cnt, busy_cnt;
        logic [4*DIGITS-1:0] exp_bcd;
        exp_bcd = model_bcd(v);
        run_conv(v, LAT + 6, 1'b0, done_at, done_cnt, busy_cnt);
        n_cmp += 4;
        if (done_at !== LAT) begin
            n_err++; $display("FAIL %s_latency got %0d want %0d", name, done_at, LAT);
        end
        if (done_cnt !== 1) begin
            n_err++; $display("FAIL %s_done_count got %0d want 1", name, done_cnt);
        end
        if (busy_cnt !== DATA_W) begin
            n_err++; $display("FAIL %s_busy_cycles got %0d want %0d", name, busy_cnt, DATA_W);
        end
        if (bcd_o !== exp_bcd) begin
            n_err++; $display("FAIL %s_bcd got %h want %h", name, bcd_o, exp_bcd);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            test_value(DATA_W'($urandom), "random");
        end
    endtask

    task automatic test_ignored_start();
        int done_at, done_cnt, busy_cnt;
        run_conv(16'd42, LAT + 10, 1'b1, done_at, done_cnt, busy_cnt);
        n_cmp += 3;
        if (done_cnt !== 1) begin n_err++; $display("FAIL ignored_done_count got %0d want 1", done_cnt); end
        if (done_at !== LAT) begin n_err++; $display("FAIL ignored_latency got %0d want %0d", done_at, LAT); end
        if (bcd_o !== 20'h00042) begin n_err++; $display("FAIL ignored_bcd got %h want 00042", bcd_o); end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] v1, v2;
        int d1, d2;
        logic [4*DIGITS-1:0] b1, b2;
        v1 = DATA_W'($urandom);
        v2 = DATA_W'($urandom);
        d1 = -1; d2 = -1; b1 = '0; b2 = '0;
        data_i = v1; start_i = 1'b1; tick(); start_i = 1'b0;
        for (int c = 0; c < 2 * LAT + 8; c++) begin
            if (done_o && d1 < 0) begin d1 = c; b1 = bcd_o; end
            else if (done_o && d2 < 0) begin d2 = c; b2 = bcd_o; end
            start_i = (c == LAT);
            data_i  = (c == LAT) ? v2 : data_i;
            tick();
        end
        start_i = 1'b0;
        n_cmp += 4;
        if (d1 !== LAT) begin n_err++; $display("FAIL b2b_first_at got %0d want %0d", d1, LAT); end
        if (d2 !== 2 * LAT + 1) begin n_err++; $display("FAIL b2b_second_at got %0d want %0d", d2, 2 * LAT + 1); end
        if (b1 !== model_bcd(v1)) begin n_err++; $display("FAIL b2b_first_bcd got %h want %h", b1, model_bcd(v1)); end
        if (b2 !== model_bcd(v2)) begin n_err++; $display("FAIL b2b_second_bcd got %h want %h", b2, model_bcd(v2)); end
    endtask

    task automatic test_scan();
        logic [DIGITS-1:0] prev;
        logic [DIGITS-1:0] exp_an;
        logic [6:0] exp_seg;
        bit found = 1'b0;
        for (int c = 0; c < 8 * SCAN_DIV * DIGITS && !found; c++) begin
            prev = an_o;
            tick();
            if (an_o === 5'h1E && prev !== 5'h1E) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL scan_align got %h want 1e", an_o); end
        for (int k = 0; k < SCAN_DIV * DIGITS; k++) begin
            exp_an  = ~(DIGITS'(1) << (k / SCAN_DIV));
            exp_seg = model_seg(20'h01234, k / SCAN_DIV);
            n_cmp += 2;
            if (an_o !== exp_an) begin
                n_err++; $display("FAIL scan_an k=%0d got %h want %h", k, an_o, exp_an);
            end
            if (seg_o !== exp_seg) begin
                n_err++; $display("FAIL scan_seg k=%0d got %h want %h", k, seg_o, exp_seg);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_conv();
        int seen = 0;
        data_i = 16'd777; start_i = 1'b1; tick(); start_i = 1'b0;
        repeat (8) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_cmp++;
        if (bcd_o !== '0) begin n_err++; $display("FAIL abort_bcd_cleared got %h want 0", bcd_o); end
        for (int c = 0; c < LAT + 6; c++) begin
            if (done_o) seen++;
            tick();
        end
        n_cmp += 3;
        if (seen !== 0) begin n_err++; $display("FAIL abort_done got %0d pulses want 0", seen); end
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL abort_busy got %h want 0", busy_o); end
        if (bcd_o !== '0) begin n_err++; $display("FAIL abort_bcd got %h want 0", bcd_o); end
        test_value(DATA_W'($urandom), "after_abort");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_value(16'hFFFF, "max");
        test_value(16'd1234, "mid");
        test_value(16'd0, "zero");
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_value(16'd1234, "scan_setup");
        test_scan();
        test_reset_mid_conv();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
